// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: arctangent table, mode encoding,
// FSM state type and the shift-add terms of the 1/gain constant.
package cordic_pkg;

  localparam int ATAN_FRAC = 30;
  localparam int ATAN_N    = 24;

  // atan(2^-i)/pi in units of 2^-30; trimmed to N_FRAC with rounding where it is used.
  localparam logic [31:0] ATAN_TAB [ATAN_N] = '{
    32'd268435456, 32'd158466703, 32'd83729454,  32'd42502379,
    32'd21333666,  32'd10677233,  32'd5339919,   32'd2670123,
    32'd1335082,   32'd667543,    32'd333772,    32'd166886,
    32'd83443,     32'd41722,     32'd20861,     32'd10430,
    32'd5215,      32'd2608,      32'd1304,      32'd652,
    32'd326,       32'd163,       32'd81,        32'd41
  };

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2,
    ST_GAIN = 2'd3
  } state_e;

  // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13; bit k of GAIN_NEG marks a subtracted term.
  localparam int          GAIN_TERMS = 5;
  localparam int          GAIN_SHIFTS [GAIN_TERMS] = '{32'sd1, 32'sd3, 32'sd6, 32'sd9, 32'sd13};
  localparam logic [4:0]  GAIN_NEG   = 5'b11100;

endpackage

// File: rtl/cordic_engine_micro_rot.sv
// Combinational CORDIC micro-rotation: direction decision, variable arithmetic
// shift and add/subtract on x, y and the angle accumulator.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int XW = 18,
  parameter int ZW = 16,
  parameter int SW = 5
) (
  input  logic                 mode_i,
  input  logic [SW-1:0]        shift_i,
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic signed [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic                 dir_pos_s;
  logic signed [XW-1:0] x_sh_s;
  logic signed [XW-1:0] y_sh_s;

  // Rotation chases z to zero, vectoring chases y to zero.
  always_comb begin
    if (mode_i == MODE_VEC) begin
      dir_pos_s = y_i[XW-1];
    end else begin
      dir_pos_s = ~z_i[ZW-1];
    end
    x_sh_s = x_i >>> shift_i;
    y_sh_s = y_i >>> shift_i;
    if (dir_pos_s) begin
      x_o = x_i - y_sh_s;
      y_o = y_i + x_sh_s;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh_s;
      y_o = y_i - x_sh_s;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine (rotation/vectoring) reusing one micro-rotation for N_ITER cycles.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales x/y by ~0.607253 before saturation.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int N_FRAC = 15,
  parameter int N_ITER = 14,
  parameter int GUARD  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mode_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [N_FRAC:0] x_i,
  input  logic signed [N_FRAC:0] y_i,
  input  logic signed [N_FRAC:0] z_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic signed [N_FRAC:0] x_o,
  output logic signed [N_FRAC:0] y_o,
  output logic signed [N_FRAC:0] z_o,
  output logic                   sat_o
);

  localparam int ZW      = N_FRAC + 1;
  localparam int XW      = ZW + GUARD;
  localparam int CW      = 5;
  localparam int ATAN_SH = ATAN_FRAC - N_FRAC;

  localparam logic [31:0]          ATAN_RND   = 32'd1 << (ATAN_SH - 1);
  localparam logic [CW-1:0]        LAST_ITER  = CW'(N_ITER - 1);
  localparam logic signed [ZW-1:0] HALF_Z     = {2'b01, {(N_FRAC-1){1'b0}}};
  localparam logic signed [ZW-1:0] NEG_HALF_Z = {2'b11, {(N_FRAC-1){1'b0}}};
  localparam logic signed [XW-1:0] SAT_HI_X   = {{(GUARD+1){1'b0}}, {N_FRAC{1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO_X   = {{(GUARD+1){1'b1}}, {N_FRAC{1'b0}}};
  localparam logic signed [ZW-1:0] SAT_HI_O   = {1'b0, {N_FRAC{1'b1}}};
  localparam logic signed [ZW-1:0] SAT_LO_O   = {1'b1, {N_FRAC{1'b0}}};

  function automatic logic signed [ZW-1:0] atan_at(input logic [CW-1:0] idx);
    return ZW'((ATAN_TAB[idx] + ATAN_RND) >> ATAN_SH);
  endfunction

  // Returns {clipped, value} after clamping the wide word to the I/O range.
  function automatic logic [ZW:0] sat_word(input logic signed [XW-1:0] v);
    logic [ZW:0] r;
    if (v > SAT_HI_X) begin
      r = {1'b1, SAT_HI_O};
    end else if (v < SAT_LO_X) begin
      r = {1'b1, SAT_LO_O};
    end else begin
      r = {1'b0, v[ZW-1:0]};
    end
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        iter_q, iter_d;
  logic                 mode_q, mode_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sat_q, sat_d;
  logic signed [ZW-1:0] res_x_q, res_x_d, res_y_q, res_y_d, res_z_q, res_z_d;

  logic signed [XW-1:0] x_ext_s, y_ext_s, x_ld_s, y_ld_s;
  logic signed [ZW-1:0] z_ld_s, atan_s;
  logic signed [XW-1:0] rot_x_s, rot_y_s, fin_x_s, fin_y_s;
  logic signed [ZW-1:0] rot_z_s, fin_z_s;
  logic [ZW:0]          sat_x_s, sat_y_s;

  // Quadrant pre-correction brings the operand into the CORDIC convergence range.
  always_comb begin
    x_ext_s = {{GUARD{x_i[ZW-1]}}, x_i};
    y_ext_s = {{GUARD{y_i[ZW-1]}}, y_i};
    x_ld_s  = x_ext_s;
    y_ld_s  = y_ext_s;
    z_ld_s  = z_i;
    if (mode_i == MODE_ROT) begin
      if (z_i > HALF_Z) begin
        x_ld_s = -y_ext_s;
        y_ld_s = x_ext_s;
        z_ld_s = z_i - HALF_Z;
      end else if (z_i < NEG_HALF_Z) begin
        x_ld_s = y_ext_s;
        y_ld_s = -x_ext_s;
        z_ld_s = z_i + HALF_Z;
      end else begin
        z_ld_s = z_i;
      end
    end else begin
      if (x_i[ZW-1] && !y_i[ZW-1]) begin
        x_ld_s = y_ext_s;
        y_ld_s = -x_ext_s;
        z_ld_s = z_i + HALF_Z;
      end else if (x_i[ZW-1]) begin
        x_ld_s = -y_ext_s;
        y_ld_s = x_ext_s;
        z_ld_s = z_i - HALF_Z;
      end else begin
        z_ld_s = z_i;
      end
    end
  end

  assign atan_s = atan_at(iter_q);

  cordic_micro_rot #(
    .XW (XW),
    .ZW (ZW),
    .SW (CW)
  ) u_micro_rot (
    .mode_i  (mode_q),
    .shift_i (iter_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .atan_i  (atan_s),
    .x_o     (rot_x_s),
    .y_o     (rot_y_s),
    .z_o     (rot_z_s)
  );

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [XW-1:0] gain_mul(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] acc;
    acc = {XW{1'b0}};
    for (int k = 0; k < GAIN_TERMS; k++) begin
      if (GAIN_NEG[k]) begin
        acc = acc - (v >>> GAIN_SHIFTS[k]);
      end else begin
        acc = acc + (v >>> GAIN_SHIFTS[k]);
      end
    end
    return acc;
  endfunction

  assign fin_x_s = gain_mul(x_q);
  assign fin_y_s = gain_mul(y_q);
  assign fin_z_s = z_q;
`else
  assign fin_x_s = rot_x_s;
  assign fin_y_s = rot_y_s;
  assign fin_z_s = rot_z_s;
`endif

  assign sat_x_s = sat_word(fin_x_s);
  assign sat_y_s = sat_word(fin_y_s);

  // Next-state and result-register logic for the IDLE/ITER/(GAIN)/DONE sequence.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    mode_d      = mode_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_z_d     = res_z_q;
    sat_d       = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          state_d = ST_ITER;
          iter_d  = {CW{1'b0}};
          mode_d  = mode_i;
          x_d     = x_ld_s;
          y_d     = y_ld_s;
          z_d     = z_ld_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        x_d    = rot_x_s;
        y_d    = rot_y_s;
        z_d    = rot_z_s;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_GAIN;
`else
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          res_x_d     = sat_x_s[ZW-1:0];
          res_y_d     = sat_y_s[ZW-1:0];
          res_z_d     = fin_z_s;
          sat_d       = sat_x_s[ZW] | sat_y_s[ZW];
`endif
        end else begin
          state_d = ST_ITER;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        res_x_d     = sat_x_s[ZW-1:0];
        res_y_d     = sat_y_s[ZW-1:0];
        res_z_d     = fin_z_s;
        sat_d       = sat_x_s[ZW] | sat_y_s[ZW];
      end
`endif
      ST_DONE: begin
        if (out_ready_i) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      iter_q      <= {CW{1'b0}};
      mode_q      <= 1'b0;
      x_q         <= {XW{1'b0}};
      y_q         <= {XW{1'b0}};
      z_q         <= {ZW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_x_q     <= {ZW{1'b0}};
      res_y_q     <= {ZW{1'b0}};
      res_z_q     <= {ZW{1'b0}};
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_z_q     <= res_z_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign x_o         = res_x_q;
  assign y_o         = res_y_q;
  assign z_o         = res_z_q;
  assign sat_o       = sat_q;

endmodule
